// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with M/W operand forwarding and load-use hazard detection.
// The E register captures Decode each edge unless a flush, hold or load-use stall intervenes.
module id_ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int ZR   = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [4:0]      ra1_d,
  input  logic [4:0]      ra2_d,
  input  logic [4:0]      wa3_d,
  input  logic            alu_src_d,
  input  logic [3:0]      alu_control_d,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic            mem_to_reg_d,
  input  logic            valid_d,
  input  logic            reg_write_m,
  input  logic [4:0]      wa3_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic            reg_write_w,
  input  logic [4:0]      wa3_w,
  input  logic [XLEN-1:0] result_w,
  input  logic            hold_e,
  input  logic            flush_e,
  output logic [XLEN-1:0] src_a_e,
  output logic [XLEN-1:0] src_b_e,
  output logic [XLEN-1:0] write_data_e,
  output logic [3:0]      alu_control_e,
  output logic [4:0]      wa3_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            mem_to_reg_e,
  output logic            valid_e,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            stall_d
);

  localparam logic [4:0] ZR_IDX = 5'(ZR);

  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_e;
  logic [4:0]      ra1_e;
  logic [4:0]      ra2_e;
  logic            alu_src_e;

  // Hold already freezes Decode, so the load-use request is suppressed while it is active.
  always_comb begin
    stall_d = 1'b0;
    if (!hold_e && valid_e && mem_to_reg_e && (wa3_e != ZR_IDX) &&
        ((ra1_d == wa3_e) || (ra2_d == wa3_e)))
      stall_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_e         <= '0;
      ra1_e         <= ZR_IDX;
      ra2_e         <= ZR_IDX;
      wa3_e         <= ZR_IDX;
      alu_src_e     <= 1'b0;
      alu_control_e <= 4'd0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      valid_e       <= 1'b0;
    end else if (flush_e || (!hold_e && stall_d)) begin
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_e         <= '0;
      ra1_e         <= ZR_IDX;
      ra2_e         <= ZR_IDX;
      wa3_e         <= ZR_IDX;
      alu_src_e     <= 1'b0;
      alu_control_e <= 4'd0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      mem_to_reg_e  <= 1'b0;
      valid_e       <= 1'b0;
    end else if (!hold_e) begin
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      imm_e         <= imm_d;
      ra1_e         <= ra1_d;
      ra2_e         <= ra2_d;
      wa3_e         <= wa3_d;
      alu_src_e     <= alu_src_d;
      alu_control_e <= alu_control_d;
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      mem_to_reg_e  <= mem_to_reg_d;
      valid_e       <= valid_d;
    end
  end

  // Memory stage is younger than Writeback, so its result takes priority.
  always_comb begin
    fwd_a_e = 2'b00;
    src_a_e = rd1_e;
    if (reg_write_m && (wa3_m != ZR_IDX) && (wa3_m == ra1_e)) begin
      fwd_a_e = 2'b10;
      src_a_e = alu_result_m;
    end else if (reg_write_w && (wa3_w != ZR_IDX) && (wa3_w == ra1_e)) begin
      fwd_a_e = 2'b01;
      src_a_e = result_w;
    end
  end

  always_comb begin
    fwd_b_e      = 2'b00;
    write_data_e = rd2_e;
    if (reg_write_m && (wa3_m != ZR_IDX) && (wa3_m == ra2_e)) begin
      fwd_b_e      = 2'b10;
      write_data_e = alu_result_m;
    end else if (reg_write_w && (wa3_w != ZR_IDX) && (wa3_w == ra2_e)) begin
      fwd_b_e      = 2'b01;
      write_data_e = result_w;
    end
  end

  assign src_b_e = alu_src_e ? imm_e : write_data_e;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage; each task drives one scenario and checks inline.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic [63:0] rd1_d, rd2_d, imm_d;
  logic [4:0]  ra1_d, ra2_d, wa3_d;
  logic        alu_src_d;
  logic [3:0]  alu_control_d;
  logic        reg_write_d, mem_write_d, mem_to_reg_d, valid_d;
  logic        reg_write_m;
  logic [4:0]  wa3_m;
  logic [63:0] alu_result_m;
  logic        reg_write_w;
  logic [4:0]  wa3_w;
  logic [63:0] result_w;
  logic        hold_e, flush_e;
  logic [63:0] src_a_e, src_b_e, write_data_e;
  logic [3:0]  alu_control_e;
  logic [4:0]  wa3_e;
  logic        reg_write_e, mem_write_e, mem_to_reg_e, valid_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_d;

  int vectors;
  int miscompares;

  id_ex_operand_stage #(.XLEN(64), .ZR(31)) dut (
    .clk(clk), .reset(reset),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .mem_to_reg_d(mem_to_reg_d), .valid_d(valid_d),
    .reg_write_m(reg_write_m), .wa3_m(wa3_m), .alu_result_m(alu_result_m),
    .reg_write_w(reg_write_w), .wa3_w(wa3_w), .result_w(result_w),
    .hold_e(hold_e), .flush_e(flush_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .write_data_e(write_data_e),
    .alu_control_e(alu_control_e), .wa3_e(wa3_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .mem_to_reg_e(mem_to_reg_e), .valid_e(valid_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_d(stall_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [63:0] rd1, input logic [63:0] rd2, input logic [63:0] imm,
                         input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa3,
                         input logic asrc, input logic [3:0] ctrl, input logic rw,
                         input logic mw, input logic m2r);
    rd1_d = rd1; rd2_d = rd2; imm_d = imm;
    ra1_d = ra1; ra2_d = ra2; wa3_d = wa3;
    alu_src_d = asrc; alu_control_d = ctrl;
    reg_write_d = rw; mem_write_d = mw; mem_to_reg_d = m2r; valid_d = 1'b1;
  endtask

  task automatic clear_mw();
    reg_write_m = 1'b0; wa3_m = 5'd0; alu_result_m = '0;
    reg_write_w = 1'b0; wa3_w = 5'd0; result_w = '0;
  endtask

  task automatic test_reset();
    clear_mw();
    hold_e = 1'b0; flush_e = 1'b0;
    drive_d(64'h11, 64'h22, 64'h33, 5'd1, 5'd2, 5'd3, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) step();
    vectors++;
    if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0 || mem_to_reg_e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got v=%b rw=%b mw=%b m2r=%b want 0000", valid_e, reg_write_e, mem_write_e, mem_to_reg_e);
    end
    vectors++;
    if (wa3_e !== 5'd31 || alu_control_e !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_wa3_ctrl: got wa3=%0d alu=%0h want 31 0", wa3_e, alu_control_e);
    end
    vectors++;
    if (src_a_e !== 64'd0 || src_b_e !== 64'd0 || fwd_a_e !== 2'b00 || fwd_b_e !== 2'b00 || stall_d !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got a=%0h b=%0h fa=%b fb=%b st=%b want 0 0 00 00 0", src_a_e, src_b_e, fwd_a_e, fwd_b_e, stall_d);
    end
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    clear_mw();
    drive_d(64'd5, 64'd3, 64'd0, 5'd4, 5'd5, 5'd1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    step();
    vectors++;
    if (src_a_e !== 64'd5 || src_b_e !== 64'd3 || valid_e !== 1'b1 || wa3_e !== 5'd1 || alu_control_e !== 4'h2) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got a=%0d b=%0d v=%b wa3=%0d alu=%0h want 5 3 1 1 2", src_a_e, src_b_e, valid_e, wa3_e, alu_control_e);
    end
    drive_d(64'd0, 64'd0, 64'd1, 5'd1, 5'd31, 5'd2, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
    step();
    reg_write_m = 1'b1; wa3_m = 5'd1; alu_result_m = 64'd8;
    #1;
    vectors++;
    if (fwd_a_e !== 2'b10 || src_a_e !== 64'd8 || src_b_e !== 64'd1) begin
      miscompares++;
      $display("[TB] FAIL b2b_fwd_m: got fa=%b a=%0d b=%0d want 10 8 1", fwd_a_e, src_a_e, src_b_e);
    end
  endtask

  task automatic test_two_apart();
    clear_mw();
    drive_d(64'd0, 64'd0, 64'd0, 5'd1, 5'd9, 5'd3, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    step();
    reg_write_w = 1'b1; wa3_w = 5'd1; result_w = 64'd8;
    #1;
    vectors++;
    if (fwd_a_e !== 2'b01 || src_a_e !== 64'd8) begin
      miscompares++;
      $display("[TB] FAIL two_apart_w: got fa=%b a=%0d want 01 8", fwd_a_e, src_a_e);
    end
    reg_write_m = 1'b1; wa3_m = 5'd1; alu_result_m = 64'd9;
    #1;
    vectors++;
    if (fwd_a_e !== 2'b10 || src_a_e !== 64'd9) begin
      miscompares++;
      $display("[TB] FAIL double_write: got fa=%b a=%0d want 10 9", fwd_a_e, src_a_e);
    end
    reg_write_m = 1'b0;
    #1;
    vectors++;
    if (fwd_a_e !== 2'b01 || src_a_e !== 64'd8) begin
      miscompares++;
      $display("[TB] FAIL m_not_writing: got fa=%b a=%0d want 01 8", fwd_a_e, src_a_e);
    end
  endtask

  task automatic test_xzr();
    clear_mw();
    drive_d(64'd0, 64'd0, 64'd0, 5'd31, 5'd31, 5'd4, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    step();
    reg_write_m = 1'b1; wa3_m = 5'd31; alu_result_m = 64'h55;
    reg_write_w = 1'b1; wa3_w = 5'd31; result_w = 64'h66;
    #1;
    vectors++;
    if (fwd_a_e !== 2'b00 || src_a_e !== 64'd0 || fwd_b_e !== 2'b00 || write_data_e !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL xzr: got fa=%b a=%0h fb=%b wd=%0h want 00 0 00 0", fwd_a_e, src_a_e, fwd_b_e, write_data_e);
    end
  endtask

  task automatic test_load_use();
    clear_mw();
    drive_d(64'h100, 64'd0, 64'h8, 5'd2, 5'd31, 5'd3, 1'b1, 4'h2, 1'b1, 1'b0, 1'b1);
    step();
    drive_d(64'd7, 64'd0, 64'd0, 5'd4, 5'd3, 5'd5, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (stall_d !== 1'b1 || mem_to_reg_e !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_use_stall: got st=%b m2r=%b want 1 1", stall_d, mem_to_reg_e);
    end
    step();
    reg_write_m = 1'b1; wa3_m = 5'd3; alu_result_m = 64'h108;
    #1;
    vectors++;
    if (valid_e !== 1'b0 || stall_d !== 1'b0 || wa3_e !== 5'd31 || reg_write_e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_use_bubble: got v=%b st=%b wa3=%0d rw=%b want 0 0 31 0", valid_e, stall_d, wa3_e, reg_write_e);
    end
    step();
    reg_write_m = 1'b0; wa3_m = 5'd31;
    reg_write_w = 1'b1; wa3_w = 5'd3; result_w = 64'h1234;
    #1;
    vectors++;
    if (valid_e !== 1'b1 || fwd_b_e !== 2'b01 || src_b_e !== 64'h1234 || src_a_e !== 64'd7 || stall_d !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_use_fwd_w: got v=%b fb=%b b=%0h a=%0h st=%b want 1 01 1234 7 0", valid_e, fwd_b_e, src_b_e, src_a_e, stall_d);
    end
  endtask

  task automatic test_imm_forward();
    clear_mw();
    drive_d(64'd0, 64'd0, 64'h10, 5'd31, 5'd6, 5'd8, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
    step();
    reg_write_m = 1'b1; wa3_m = 5'd6; alu_result_m = 64'hAA;
    #1;
    vectors++;
    if (src_b_e !== 64'h10 || write_data_e !== 64'hAA || fwd_b_e !== 2'b10 || mem_write_e !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL imm_fwd: got b=%0h wd=%0h fb=%b mw=%b want 10 aa 10 1", src_b_e, write_data_e, fwd_b_e, mem_write_e);
    end
  endtask

  task automatic test_hold_flush();
    clear_mw();
    drive_d(64'h40, 64'h41, 64'h0, 5'd10, 5'd11, 5'd7, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1);
    step();
    drive_d(64'h50, 64'h51, 64'h0, 5'd7, 5'd12, 5'd13, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
    hold_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (valid_e !== 1'b1 || wa3_e !== 5'd7 || alu_control_e !== 4'h9 || src_a_e !== 64'h40 ||
          write_data_e !== 64'h41 || mem_to_reg_e !== 1'b1 || stall_d !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got v=%b wa3=%0d alu=%0h a=%0h wd=%0h m2r=%b st=%b want 1 7 9 40 41 1 0",
                 i, valid_e, wa3_e, alu_control_e, src_a_e, write_data_e, mem_to_reg_e, stall_d);
      end
    end
    flush_e = 1'b1;
    step();
    flush_e = 1'b0; hold_e = 1'b0;
    #1;
    vectors++;
    if (valid_e !== 1'b0 || wa3_e !== 5'd31 || alu_control_e !== 4'd0 || mem_to_reg_e !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_over_hold: got v=%b wa3=%0d alu=%0h m2r=%b want 0 31 0 0", valid_e, wa3_e, alu_control_e, mem_to_reg_e);
    end
  endtask

  task automatic test_async_reset();
    clear_mw();
    drive_d(64'h70, 64'h71, 64'h0, 5'd14, 5'd15, 5'd16, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
    step();
    drive_d(64'h80, 64'h81, 64'h0, 5'd16, 5'd17, 5'd18, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (stall_d !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_stall: got %b want 1", stall_d);
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (valid_e !== 1'b0 || stall_d !== 1'b0 || wa3_e !== 5'd31 || alu_control_e !== 4'd0 || src_a_e !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got v=%b st=%b wa3=%0d alu=%0h a=%0h want 0 0 31 0 0", valid_e, stall_d, wa3_e, alu_control_e, src_a_e);
    end
    reset = 1'b1;
    step();
    vectors++;
    if (valid_e !== 1'b1 || wa3_e !== 5'd18 || alu_control_e !== 4'hB || src_a_e !== 64'h80) begin
      miscompares++;
      $display("[TB] FAIL post_reset_load: got v=%b wa3=%0d alu=%0h a=%0h want 1 18 b 80", valid_e, wa3_e, alu_control_e, src_a_e);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_back_to_back();
    test_two_apart();
    test_xzr();
    test_load_use();
    test_imm_forward();
    test_hold_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage of the ARM64 pipeline. It captures decoded operands and control at the end of Decode. It resolves RAW hazards by forwarding from Memory and Writeback, and delivers final `a`/`b` operands and `ALUControl` to the ALU in Execute. It also detects load-use hazards, stalls Decode, and injects bubbles.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `ZR`, 31, register index that is never forwarded (XZR).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `rd1_d`, `rd2_d` in XLEN: register-file read data from Decode.
- `imm_d` in XLEN: extended immediate.
- `ra1_d`, `ra2_d`, `wa3_d` in 5: source and destination register indices.
- `alu_src_d` in 1: 1 selects `imm` as operand b.
- `alu_control_d` in 4: ALU opcode.
- `reg_write_d`, `mem_write_d`, `mem_to_reg_d`, `valid_d` in 1: Decode control bits.
- `reg_write_m` in 1, `wa3_m` in 5, `alu_result_m` in XLEN: Memory-stage forwarding source.
- `reg_write_w` in 1, `wa3_w` in 5, `result_w` in XLEN: Writeback-stage forwarding source.
- `hold_e` in 1: freeze the E register (downstream memory stall).
- `flush_e` in 1: squash the instruction entering E (branch redirect).
- `src_a_e`, `src_b_e` out XLEN: ALU `a` and `b`.
- `write_data_e` out XLEN: forwarded rd2 (store data).
- `alu_control_e` out 4: ALU opcode.
- `wa3_e` out 5; `reg_write_e`, `mem_write_e`, `mem_to_reg_e`, `valid_e` out 1.
- `fwd_a_e`, `fwd_b_e` out 2: forwarding select (00 register file, 10 from M, 01 from W).
- `stall_d` out 1: load-use stall request to Fetch/Decode.

## Operation
- E register fields: `rd1`, `rd2`, `imm`, `ra1`, `ra2`, `wa3`, `alu_src`, `alu_control`, `reg_write`, `mem_write`, `mem_to_reg`, `valid`.
- Per-edge update priority, highest first:
  - `flush_e`: load a bubble.
  - `hold_e`: retain all fields.
  - `stall_d`: load a bubble.
  - Otherwise: load the Decode inputs.
- Bubble: `valid`, `reg_write`, `mem_write`, `mem_to_reg` = 0; `wa3` = `ZR`; `ra1`/`ra2` = `ZR`; data fields and `alu_control` = 0.
- `stall_d` = `valid_e & mem_to_reg_e & (wa3_e != ZR) & ((ra1_d == wa3_e) | (ra2_d == wa3_e))`. It is forced to 0 while `hold_e` = 1, because the freeze already holds Decode.
- Forwarding for operand A (combinational from E-register fields):
  - If `reg_write_m & wa3_m != ZR & wa3_m == ra1_e`: select 10 (`alu_result_m`).
  - Else if `reg_write_w & wa3_w != ZR & wa3_w == ra1_e`: select 01 (`result_w`).
  - Else select 00 (`rd1_e`).
  - M has priority over W.
- Operand B uses the same rule with `ra2_e`/`rd2_e`, producing `write_data_e`.
- `src_a_e` = forwarded A.
- `src_b_e` = `imm_e` if `alu_src_e`, else `write_data_e`. `fwd_b_e` still reports the rd2 path selection.
- Reserved select value 11 never occurs.
- All other outputs are direct register contents.

## Timing
- Decode to E latency is 1 cycle. Forwarding and `stall_d` are combinational within the cycle (no added latency).
- Reset (`reset` = 0, asynchronous): E register loads a bubble. Outputs:
  - `valid_e`, `reg_write_e`, `mem_write_e`, `mem_to_reg_e` = 0.
  - `alu_control_e` = 0; `wa3_e` = 31.
  - `fwd_a_e` = `fwd_b_e` = 00; `stall_d` = 0.
  - `src_a_e` = `src_b_e` = 0 only if no M/W forward is active.
- Reset asserted mid-stall clears the stall on the same cycle. The first edge after deassertion loads Decode.
- A load-use stall lasts exactly 1 cycle per load (the bubble removes the match). After it, the W-stage forward supplies the loaded data.
- Simultaneous `flush_e` and `hold_e`: flush wins; the held instruction is discarded.
- Forwarding is valid only when the producing stage holds a real write. Bubbles carry `reg_write` = 0 and never forward.

## Test plan
- **Back-to-back ADD.** Issue X1 = 5+3, then X2 = X1 − 1. Required: in E of the second instruction, `fwd_a_e` = 10 and `src_a_e` = 8 (from `alu_result_m`).
- **Two-apart and double-write.** Write X1 two instructions ahead (W holds 8). Required: `fwd_a_e` = 01. When both M (X1 = 9) and W (X1 = 8) match, `src_a_e` = 9.
- **XZR.** `reg_write_m` = 1, `wa3_m` = 31, `ra1_e` = 31, `rd1_e` = 0. Required: `fwd_a_e` = 00 and `src_a_e` = 0.
- **Load-use.** LDUR X3 in E, then ADD with `ra2_d` = 3. Required: `stall_d` = 1 for one cycle, then `valid_e` = 0 for one cycle; ADD enters next with `fwd_b_e` = 01 and `src_b_e` = `result_w`.
- **Immediate with forward.** `alu_src_e` = 1, `imm_e` = 0x10, rd2 forwarded from M = 0xAA. Required: `src_b_e` = 0x10, `write_data_e` = 0xAA.
- **Flush/hold/reset.** `hold_e` = 1 for 3 cycles: all outputs stable. `flush_e` = `hold_e` = 1: `valid_e` = 0 next cycle. Async `reset` pulse mid-cycle: outputs reach reset values immediately, without waiting for a clock edge.
